// File: rtl/op_scheduler_if.sv
// Command, controller-configuration and completion signals shared by
// op_scheduler (slave side) and its surrounding fabric (master side).
interface op_scheduler_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [1:0]            req0_opcode;
    logic [ADDR_WIDTH-1:0] req0_op1_addr;
    logic [ADDR_WIDTH-1:0] req0_op2_addr;
    logic [ADDR_WIDTH-1:0] req0_out_addr;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [1:0]            req1_opcode;
    logic [ADDR_WIDTH-1:0] req1_op1_addr;
    logic [ADDR_WIDTH-1:0] req1_op2_addr;
    logic [ADDR_WIDTH-1:0] req1_out_addr;

    logic                  cfg_en;
    logic [1:0]            cfg_opcode;
    logic [ADDR_WIDTH-1:0] cfg_op1_addr;
    logic [ADDR_WIDTH-1:0] cfg_op2_addr;
    logic [ADDR_WIDTH-1:0] cfg_out_addr;
    logic                  ctrl_done;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic                  rsp_timeout;
    logic                  busy;

    modport master (
        output req0_valid, req0_opcode, req0_op1_addr, req0_op2_addr, req0_out_addr,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_op1_addr, req1_op2_addr, req1_out_addr,
        input  req1_ready,
        input  cfg_en, cfg_opcode, cfg_op1_addr, cfg_op2_addr, cfg_out_addr,
        output ctrl_done,
        input  rsp_valid, rsp_id, rsp_timeout, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_op1_addr, req0_op2_addr, req0_out_addr,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_op1_addr, req1_op2_addr, req1_out_addr,
        output req1_ready,
        output cfg_en, cfg_opcode, cfg_op1_addr, cfg_op2_addr, cfg_out_addr,
        input  ctrl_done,
        output rsp_valid, rsp_id, rsp_timeout, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/op_scheduler.sv
// Round-robin front end for the FHE operation controller: one command in
// flight, one-cycle config strobe, done-or-timeout completion response.
module op_scheduler #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7
) (
    input logic          clk,
    input logic          rst_n,
    op_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]            cfg_opcode_q, cfg_opcode_d;
    logic [ADDR_WIDTH-1:0] cfg_op1_addr_q, cfg_op1_addr_d;
    logic [ADDR_WIDTH-1:0] cfg_op2_addr_q, cfg_op2_addr_d;
    logic [ADDR_WIDTH-1:0] cfg_out_addr_q, cfg_out_addr_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic grant;
    logic idle_open;
    logic accept;

    always_comb begin
        grant = ptr_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
    end

    // rst_n gates ready so nothing is offered while reset is held.
    assign idle_open      = rst_n && (state_q == IDLE);
    assign bus.req0_ready = idle_open && !grant;
    assign bus.req1_ready = idle_open && grant;
    assign accept         = (bus.req0_valid && bus.req0_ready) ||
                            (bus.req1_valid && bus.req1_ready);

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        cfg_opcode_d   = cfg_opcode_q;
        cfg_op1_addr_d = cfg_op1_addr_q;
        cfg_op2_addr_d = cfg_op2_addr_q;
        cfg_out_addr_d = cfg_out_addr_q;
        rsp_id_d       = rsp_id_q;
        rsp_timeout_d  = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ISSUE;
                    rsp_id_d = grant;
                    ptr_d    = ~grant;
                    if (grant) begin
                        cfg_opcode_d   = bus.req1_opcode;
                        cfg_op1_addr_d = bus.req1_op1_addr;
                        cfg_op2_addr_d = bus.req1_op2_addr;
                        cfg_out_addr_d = bus.req1_out_addr;
                    end else begin
                        cfg_opcode_d   = bus.req0_opcode;
                        cfg_op1_addr_d = bus.req0_op1_addr;
                        cfg_op2_addr_d = bus.req0_op2_addr;
                        cfg_out_addr_d = bus.req0_out_addr;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + TO_WIDTH'(1);
                // First WAIT cycle ignores done so a level left over from the
                // previous command cannot complete this one.
                if ((cnt_q != '0) && bus.ctrl_done) begin
                    state_d       = RESP;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = RESP;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            cnt_q          <= '0;
            cfg_opcode_q   <= '0;
            cfg_op1_addr_q <= '0;
            cfg_op2_addr_q <= '0;
            cfg_out_addr_q <= '0;
            rsp_id_q       <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            cfg_opcode_q   <= cfg_opcode_d;
            cfg_op1_addr_q <= cfg_op1_addr_d;
            cfg_op2_addr_q <= cfg_op2_addr_d;
            cfg_out_addr_q <= cfg_out_addr_d;
            rsp_id_q       <= rsp_id_d;
            rsp_timeout_q  <= rsp_timeout_d;
        end
    end

    assign bus.cfg_en       = (state_q == ISSUE);
    assign bus.cfg_opcode   = cfg_opcode_q;
    assign bus.cfg_op1_addr = cfg_op1_addr_q;
    assign bus.cfg_op2_addr = cfg_op2_addr_q;
    assign bus.cfg_out_addr = cfg_out_addr_q;
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_op_scheduler.sv
// Scoreboard bench for op_scheduler: a transaction-level model predicts
// grant order, config contents, completion kind and latency.
module tb_op_scheduler;
    localparam int AW = 10;
    localparam int T  = 8;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] ao;
    } cfg_t;

    typedef struct {
        bit id;
        bit to;
        int lat;
    } rsp_t;

    logic clk;
    logic rst_n;
    op_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    op_scheduler #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(T),
        .TO_WIDTH      (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   dly    = 4;  // controller done delay after cfg_en; <0 means never
    bit   mptr   = 1'b0;
    cfg_t cfg_q[$];
    rsp_t rsp_q[$];

    logic [1:0]    p_op[2];
    logic [AW-1:0] p_a1[2];
    logic [AW-1:0] p_a2[2];
    logic [AW-1:0] p_ao[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic rsp_t expect_rsp(input bit id, input int d);
        rsp_t r;
        int   j;
        r.id = id;
        r.to = 1'b0;
        if (d < 0) begin
            j    = T - 1;
            r.to = 1'b1;
        end else begin
            j = (d - 1 > 1) ? d - 1 : 1;
            if (j > T - 1) begin
                j    = T - 1;
                r.to = 1'b1;
            end
        end
        r.lat = j + 2;
        return r;
    endfunction

    task automatic drive(input int r, input bit v);
        if (r == 0) begin
            bus.req0_valid    = v;
            bus.req0_opcode   = p_op[0];
            bus.req0_op1_addr = p_a1[0];
            bus.req0_op2_addr = p_a2[0];
            bus.req0_out_addr = p_ao[0];
        end else begin
            bus.req1_valid    = v;
            bus.req1_opcode   = p_op[1];
            bus.req1_op1_addr = p_a1[1];
            bus.req1_op2_addr = p_a2[1];
            bus.req1_out_addr = p_ao[1];
        end
    endtask

    task automatic load(input int r);
        p_op[r] = 2'($urandom_range(0, 3));
        p_a1[r] = AW'($urandom);
        p_a2[r] = AW'($urandom);
        p_ao[r] = AW'($urandom);
        drive(r, 1'b1);
    endtask

    // Issues n accepts; the model decides which requester must win each one.
    task automatic send(input int n, input bit use0, input bit use1);
        int   got = 0;
        int   budget = 300;
        int   w;
        int   acc;
        cfg_t c;
        if (use0 && !bus.req0_valid) load(0);
        if (use1 && !bus.req1_valid) load(1);
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                if (bus.req0_valid && bus.req1_valid) w = int'(mptr);
                else w = bus.req0_valid ? 0 : 1;
                chk("grant", {62'd0, bus.req1_ready, bus.req0_ready}, (w == 0) ? 64'd1 : 64'd2);
                c.op = p_op[w]; c.a1 = p_a1[w]; c.a2 = p_a2[w]; c.ao = p_ao[w];
                cfg_q.push_back(c);
                rsp_q.push_back(expect_rsp(w[0], dly));
                mptr = (w == 0);
                got++;
                acc = (bus.req0_valid && bus.req0_ready) ? 0 : 1;
                @(posedge clk);
                #1;
                if (got < n) begin
                    load(acc);
                end else begin
                    drive(0, 1'b0);
                    drive(1, 1'b0);
                end
            end
        end
        if (got < n) begin
            fail("send_no_accept");
            drive(0, 1'b0);
            drive(1, 1'b0);
        end
    endtask

    task automatic drain();
        int b = 0;
        while (rsp_q.size() != 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (rsp_q.size() != 0) begin
            fail("drain_no_response");
            rsp_q.delete();
        end
        chk("cfg_all_issued", 64'(cfg_q.size()), 64'd0);
        cfg_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.cfg_en, bus.cfg_opcode, bus.cfg_op1_addr, bus.cfg_op2_addr,
                   bus.cfg_out_addr, bus.rsp_valid, bus.rsp_id, bus.rsp_timeout,
                   bus.busy, bus.req0_ready, bus.req1_ready}, 64'd0);
    endtask

    // Controller stand-in: done rises dly cycles after the cfg_en cycle and holds.
    initial begin
        int since = 1000;
        bus.ctrl_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) since = 1000;
            else if (bus.cfg_en) since = 0;
            else if (since < 1000) since++;
            bus.ctrl_done = (dly >= 0) && (since >= dly);
        end
    end

    // Monitor: pops expectations as the DUT presents config and responses.
    initial begin
        int   cfg_cyc = 0;
        bit   started = 1'b0;
        cfg_t c;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                started = 1'b0;
            end else begin
                if (bus.cfg_en) begin
                    if (cfg_q.size() == 0) begin
                        fail("cfg_en_unexpected");
                    end else begin
                        c = cfg_q.pop_front();
                        chk("cfg_fields", {bus.cfg_opcode, bus.cfg_op1_addr, bus.cfg_op2_addr, bus.cfg_out_addr},
                            {c.op, c.a1, c.a2, c.ao});
                    end
                    cfg_cyc = cyc;
                end
                if (bus.rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        fail("rsp_valid_unexpected");
                    end else begin
                        e = rsp_q[0];
                        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
                        chk("req_ready_in_resp", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
                        if (!started) begin
                            chk("rsp_latency", 64'(cyc - cfg_cyc), 64'(e.lat));
                            started = 1'b1;
                        end
                        if (bus.rsp_ready) begin
                            void'(rsp_q.pop_front());
                            started = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int u;
        int b;
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        load(0);
        load(1);

        // Reset with both requesters valid, then round-robin across 4 commands.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk_all_zero("reset_outputs");
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        dly = 4;
        send(4, 1'b1, 1'b1);
        drain();

        // Single fixed command, done 4 cycles after cfg_en.
        p_op[0] = 2'b10;
        p_a1[0] = AW'(10'h010);
        p_a2[0] = AW'(10'h020);
        p_ao[0] = AW'(10'h030);
        drive(0, 1'b1);
        send(1, 1'b1, 1'b0);
        drain();

        // Done held high throughout.
        dly = 0;
        send(2, 1'b1, 1'b1);
        drain();

        // Timeout, done in final WAIT cycle, done one cycle too late.
        dly = -1;
        send(1, 1'b0, 1'b1);
        drain();
        dly = T;
        send(1, 1'b1, 1'b0);
        drain();
        dly = T + 1;
        send(1, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 8; i++) begin
            dly = int'($urandom_range(0, 11)) - 1;
            u   = int'($urandom_range(1, 3));
            send((u == 3) ? 2 : 1, u[0], u[1]);
            drain();
        end

        // Backpressure: response held for 5 cycles.
        bus.rsp_ready = 1'b0;
        dly = 2;
        send(1, 1'b0, 1'b1);
        b = 0;
        while (!bus.rsp_valid && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!bus.rsp_valid) fail("bp_no_rsp_valid");
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_after_handshake", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
        drain();

        // Reset during WAIT drops the command; next one comes from req0.
        dly = -1;
        send(1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        rsp_q.delete();
        cfg_q.delete();
        mptr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_mid_wait");
        @(posedge clk);
        #1 rst_n = 1'b1;
        dly = 3;
        send(1, 1'b1, 1'b1);
        drain();
        drive(0, 1'b0);
        drive(1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
